// File: rtl/bip_pkg.sv
// bip_pkg: shared opcodes, select codes, decode bundle and state encoding for the BIP control unit
package bip_pkg;
  localparam int INSTR_W = 16;
  localparam int OPND_W = 11;
  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;
  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc_imm;
    logic       wr_ram;
    logic       rd_ram;
    logic       is_halt;
  } ctrl_t;
endpackage

// File: rtl/bip_control_unit_if.sv
// bip_control_unit_if: fetch, data-memory and datapath-control signals around the BIP control unit
interface bip_control_unit_if #(parameter int ADDR_W = 11, parameter int CNT_W = 32);
  import bip_pkg::*;
  logic                start;
  logic                instr_req;
  logic [ADDR_W-1:0]   instr_addr;
  logic [INSTR_W-1:0]  instr_data;
  logic                instr_valid;
  logic [OPND_W-1:0]   operand;
  logic                rd_ram;
  logic                data_valid;
  logic                wr_ram;
  logic [1:0]          sel_a;
  logic                sel_b;
  logic                alu_op;
  logic                wr_acc;
  logic                halted;
  logic [CNT_W-1:0]    cycle_count;
  modport master (
    input  start, instr_data, instr_valid, data_valid,
    output instr_req, instr_addr, operand, rd_ram, wr_ram, sel_a, sel_b, alu_op, wr_acc, halted, cycle_count
  );
  modport slave (
    output start, instr_data, instr_valid, data_valid,
    input  instr_req, instr_addr, operand, rd_ram, wr_ram, sel_a, sel_b, alu_op, wr_acc, halted, cycle_count
  );
endinterface

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode to datapath/memory control decode
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_HLT:  ctrl_o.is_halt = 1'b1;
      OP_STO:  ctrl_o.wr_ram = 1'b1;
      OP_LD:   ctrl_o = '{sel_a: SELA_RAM, rd_ram: 1'b1, default: '0};
      OP_LDI:  ctrl_o = '{sel_a: SELA_IMM, wr_acc_imm: 1'b1, default: '0};
      OP_ADD:  ctrl_o = '{sel_a: SELA_ALU, rd_ram: 1'b1, default: '0};
      OP_ADDI: ctrl_o = '{sel_a: SELA_ALU, sel_b: 1'b1, wr_acc_imm: 1'b1, default: '0};
      OP_SUB:  ctrl_o = '{sel_a: SELA_ALU, alu_op: 1'b1, rd_ram: 1'b1, default: '0};
      OP_SUBI: ctrl_o = '{sel_a: SELA_ALU, sel_b: 1'b1, alu_op: 1'b1, wr_acc_imm: 1'b1, default: '0};
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator datapath
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 32
)(
  input  logic               clk,
  input  logic               rst,
  bip_control_unit_if.master bus
);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl;
  logic               active, exec_q, wait_q;

  bip_decoder u_dec (
    .opcode_i (ir_q[INSTR_W-1 -: OPC_W]),
    .ctrl_o   (ctrl)
  );

  assign exec_q = state_q == S_EXEC;
  assign wait_q = state_q == S_WAIT;
  assign active = state_q inside {S_FETCH, S_EXEC, S_WAIT};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = (active && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_FETCH;
        pc_d    = '0;
      end
      S_FETCH: if (bus.instr_valid) begin
        state_d = S_EXEC;
        ir_d    = bus.instr_data;
      end
      S_EXEC: begin
        state_d = ctrl.is_halt ? S_HALT : ctrl.rd_ram ? S_WAIT : S_FETCH;
        pc_d    = (ctrl.is_halt || ctrl.rd_ram) ? pc_q : pc_q + 1'b1;
      end
      S_WAIT: if (bus.data_valid) begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
      end
      default: state_d = state_q;
    endcase
  end

  // Data-path selects stay valid across EXEC and WAIT so the RAM-sourced write lands correctly.
  always_comb begin
    bus.instr_req   = state_q == S_FETCH;
    bus.instr_addr  = pc_q;
    bus.operand     = ir_q[OPND_W-1:0];
    bus.rd_ram      = (exec_q && ctrl.rd_ram) || wait_q;
    bus.wr_ram      = exec_q && ctrl.wr_ram;
    bus.sel_a       = (exec_q || wait_q) ? ctrl.sel_a : SELA_RAM;
    bus.sel_b       = (exec_q || wait_q) && ctrl.sel_b;
    bus.alu_op      = (exec_q || wait_q) && ctrl.alu_op;
    bus.wr_acc      = exec_q ? ctrl.wr_acc_imm : (wait_q && bus.data_valid);
    bus.halted      = state_q == S_HALT;
    bus.cycle_count = cnt_q;
  end
endmodule
